ip_arp_resolve: RTL and testbench
=================================

IP_ARP_RESOLVE -- requirements
Module: ip_arp_resolve

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, payload width in bits; KEEP_WIDTH = DATA_WIDTH/8 is derived internally.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_ip_hdr_valid  input  1  outgoing IP frame header valid.
REQ-005 s_ip_hdr_ready  output  1  header accepted.
REQ-006 s_ip_dest_ip  input  32  next-hop IPv4 address to resolve.
REQ-007 s_ip_payload_axis_tdata  input  DATA_WIDTH  frame payload.
REQ-008 s_ip_payload_axis_tkeep  input  KEEP_WIDTH  byte enables.
REQ-009 s_ip_payload_axis_tvalid  input  1  payload valid.
REQ-010 s_ip_payload_axis_tready  output  1  payload ready.
REQ-011 s_ip_payload_axis_tlast  input  1  last payload beat.
REQ-012 s_ip_payload_axis_tuser  input  1  bad-frame flag.
REQ-013 m_eth_hdr_valid  output  1  Ethernet header valid.
REQ-014 m_eth_hdr_ready  input  1  Ethernet header accepted.
REQ-015 m_eth_dest_mac  output  48  resolved MAC.
REQ-016 m_eth_src_mac  output  48  equals local_mac.
REQ-017 m_eth_type  output  16  constant 16'h0800.
REQ-018 m_eth_payload_axis_tdata/tkeep/tvalid/tready/tlast/tuser  output(tready input)  DATA_WIDTH/KEEP_WIDTH/1/1/1/1  payload pass-through.
REQ-019 arp_request_valid  output  1  lookup request to arp.
REQ-020 arp_request_ready  input  1  lookup request accepted.
REQ-021 arp_request_ip  output  32  IP being looked up.
REQ-022 arp_response_valid  input  1  lookup result valid.
REQ-023 arp_response_ready  output  1  result accepted.
REQ-024 arp_response_error  input  1  lookup failed (timeout).
REQ-025 arp_response_mac  input  48  resolved MAC.
REQ-026 local_mac  input  48  station MAC, sampled at header accept.
REQ-027 drop_frame  output  1  one-cycle pulse per dropped frame.

Function
REQ-028 FSM states SHALL be IDLE, LOOKUP, WAIT_RESP, HDR, PASS, DROP.
REQ-029 IDLE: s_ip_hdr_ready=1; on handshake latch dest_ip and local_mac, go LOOKUP (arp_request_valid asserted next cycle).
REQ-030 LOOKUP: arp_request_valid=1, arp_request_ip=latched IP, held stable until arp_request_ready, then WAIT_RESP.
REQ-031 WAIT_RESP: arp_response_ready=1; on valid with error=0 latch MAC, go HDR (m_eth_hdr_valid next cycle); with error=1 go DROP and pulse drop_frame.
REQ-032 HDR: m_eth_hdr_valid=1, fields stable until m_eth_hdr_ready, then PASS; payload tready=0 in all states except PASS and DROP.
REQ-033 PASS: combinational payload pass-through (m tvalid=s tvalid, s tready=m tready, data/keep/last/user direct); tlast handshake -> IDLE.
REQ-034 DROP: s_ip_payload_axis_tready=1, m tvalid=0; tlast beat -> IDLE; a single-beat frame returns to IDLE after one beat.
REQ-035 Payload arriving before PASS/DROP SHALL be stalled, never lost; one frame in flight at a time.

Reset
REQ-036 rst SHALL force IDLE and all valid/ready outputs, drop_frame and latched fields to 0 on the next edge, including mid-lookup or mid-frame (outstanding request abandoned, downstream frame truncated).

Configuration
REQ-037 IP_ARP_RESOLVE_CACHE_EN defined: one-entry IP/MAC register filled on successful response, cleared by rst or an error for the same IP; header hit goes IDLE->HDR directly (m_eth_hdr_valid one cycle after accept, no ARP request); undefined: every frame performs a lookup.

Structure
REQ-038 Package ip_arp_resolve_pkg SHALL hold the state encoding and ETH_TYPE_IPV4=16'h0800; no sub-module, single FSM plus registers.

Verification
REQ-039 Header IP 192.168.1.101, response MAC 5A:51:52:53:54:55 error=0 -> m_eth_dest_mac=5A5152535455, type 0x0800, 4-beat payload bit-exact.
REQ-040 Response error=1 for 10.0.0.9 -> drop_frame one-cycle pulse, 3-beat payload consumed, no m_eth_hdr_valid.
REQ-041 arp_request_ready low 5 cycles, m_eth_hdr_ready low 3 cycles, random m tready -> request/header stable, no beat lost or duplicated.
REQ-042 rst asserted in WAIT_RESP -> all outputs 0 next cycle; next frame resolves normally.
REQ-043 With IP_ARP_RESOLVE_CACHE_EN, two frames to 192.168.1.101 -> one ARP request only; second header one cycle after accept.

Source files
------------

// File: rtl/ip_arp_resolve_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ip_arp_resolve_pkg
//  Brief    : State encoding and constants shared by the IP->Ethernet resolver.
//  Revision : 1.0  initial release
// ============================================================================
package ip_arp_resolve_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WAIT_RESP = 3'd2,
        HDR       = 3'd3,
        PASS      = 3'd4,
        DROP      = 3'd5
    } state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

endpackage
`default_nettype wire

// File: rtl/ip_arp_resolve_if.sv
`default_nettype none
// ============================================================================
//  Module   : ip_arp_resolve_if
//  Brief    : IP header/payload in, Ethernet header/payload out, ARP lookup port.
//             master = resolver side, slave = surrounding stack.
//  Revision : 1.0  initial release
// ============================================================================
interface ip_arp_resolve_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  s_ip_hdr_valid;
    logic                  s_ip_hdr_ready;
    logic [31:0]           s_ip_dest_ip;
    logic [DATA_WIDTH-1:0] s_ip_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep;
    logic                  s_ip_payload_axis_tvalid;
    logic                  s_ip_payload_axis_tready;
    logic                  s_ip_payload_axis_tlast;
    logic                  s_ip_payload_axis_tuser;

    logic                  m_eth_hdr_valid;
    logic                  m_eth_hdr_ready;
    logic [47:0]           m_eth_dest_mac;
    logic [47:0]           m_eth_src_mac;
    logic [15:0]           m_eth_type;
    logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep;
    logic                  m_eth_payload_axis_tvalid;
    logic                  m_eth_payload_axis_tready;
    logic                  m_eth_payload_axis_tlast;
    logic                  m_eth_payload_axis_tuser;

    logic                  arp_request_valid;
    logic                  arp_request_ready;
    logic [31:0]           arp_request_ip;
    logic                  arp_response_valid;
    logic                  arp_response_ready;
    logic                  arp_response_error;
    logic [47:0]           arp_response_mac;

    modport master (
        input  s_ip_hdr_valid, s_ip_dest_ip,
        input  s_ip_payload_axis_tdata, s_ip_payload_axis_tkeep, s_ip_payload_axis_tvalid,
        input  s_ip_payload_axis_tlast, s_ip_payload_axis_tuser,
        input  m_eth_hdr_ready, m_eth_payload_axis_tready,
        input  arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
        output s_ip_hdr_ready, s_ip_payload_axis_tready,
        output m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        output m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep, m_eth_payload_axis_tvalid,
        output m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        output arp_request_valid, arp_request_ip, arp_response_ready
    );

    modport slave (
        output s_ip_hdr_valid, s_ip_dest_ip,
        output s_ip_payload_axis_tdata, s_ip_payload_axis_tkeep, s_ip_payload_axis_tvalid,
        output s_ip_payload_axis_tlast, s_ip_payload_axis_tuser,
        output m_eth_hdr_ready, m_eth_payload_axis_tready,
        output arp_request_ready, arp_response_valid, arp_response_error, arp_response_mac,
        input  s_ip_hdr_ready, s_ip_payload_axis_tready,
        input  m_eth_hdr_valid, m_eth_dest_mac, m_eth_src_mac, m_eth_type,
        input  m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep, m_eth_payload_axis_tvalid,
        input  m_eth_payload_axis_tlast, m_eth_payload_axis_tuser,
        input  arp_request_valid, arp_request_ip, arp_response_ready
    );

endinterface
`default_nettype wire

// File: rtl/ip_arp_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : ip_arp_resolve
//  Brief    : Resolves the next-hop MAC through ARP, then emits an Ethernet
//             header and passes the payload through (or drops the frame).
//             Optional one-entry cache: define IP_ARP_RESOLVE_CACHE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ip_arp_resolve
    import ip_arp_resolve_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [47:0]             local_mac,
    output logic                    drop_frame,
    ip_arp_resolve_if.master        bus
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    state_t      r_state;
    logic        r_hdr_ready;
    logic        r_req_valid;
    logic        r_resp_ready;
    logic        r_hdr_valid;
    logic        r_drop;
    logic [31:0] r_dest_ip;
    logic [47:0] r_dest_mac;
    logic [47:0] r_src_mac;
`ifdef IP_ARP_RESOLVE_CACHE_EN
    logic        r_cache_valid;
    logic [31:0] r_cache_ip;
    logic [47:0] r_cache_mac;
`endif

    logic                  w_pass;
    logic                  w_drop;
    logic                  w_in_fire;
    logic [DATA_WIDTH-1:0] w_data;
    logic [KEEP_WIDTH-1:0] w_keep;

    // Payload only moves in PASS (through) or DROP (sunk); elsewhere it stalls.
    assign w_pass    = (r_state == PASS);
    assign w_drop    = (r_state == DROP);
    assign w_in_fire = bus.s_ip_payload_axis_tvalid & bus.s_ip_payload_axis_tready;
    assign w_data    = bus.s_ip_payload_axis_tdata;
    assign w_keep    = bus.s_ip_payload_axis_tkeep;

    assign bus.s_ip_payload_axis_tready  = w_pass ? bus.m_eth_payload_axis_tready : w_drop;
    assign bus.m_eth_payload_axis_tvalid = w_pass & bus.s_ip_payload_axis_tvalid;
    assign bus.m_eth_payload_axis_tdata  = w_data;
    assign bus.m_eth_payload_axis_tkeep  = w_keep;
    assign bus.m_eth_payload_axis_tlast  = bus.s_ip_payload_axis_tlast;
    assign bus.m_eth_payload_axis_tuser  = bus.s_ip_payload_axis_tuser;

    assign bus.s_ip_hdr_ready     = r_hdr_ready;
    assign bus.arp_request_valid  = r_req_valid;
    assign bus.arp_request_ip     = r_dest_ip;
    assign bus.arp_response_ready = r_resp_ready;
    assign bus.m_eth_hdr_valid    = r_hdr_valid;
    assign bus.m_eth_dest_mac     = r_dest_mac;
    assign bus.m_eth_src_mac      = r_src_mac;
    assign bus.m_eth_type         = ETH_TYPE_IPV4;
    assign drop_frame             = r_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hdr_ready  <= 1'b0;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_drop       <= 1'b0;
            r_dest_ip    <= '0;
            r_dest_mac   <= '0;
            r_src_mac    <= '0;
`ifdef IP_ARP_RESOLVE_CACHE_EN
            r_cache_valid <= 1'b0;
            r_cache_ip    <= '0;
            r_cache_mac   <= '0;
`endif
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_hdr_ready <= 1'b1;
                    if (r_hdr_ready && bus.s_ip_hdr_valid) begin
                        r_hdr_ready <= 1'b0;
                        r_dest_ip   <= bus.s_ip_dest_ip;
                        r_src_mac   <= local_mac;
`ifdef IP_ARP_RESOLVE_CACHE_EN
                        if (r_cache_valid && (r_cache_ip == bus.s_ip_dest_ip)) begin
                            r_dest_mac  <= r_cache_mac;
                            r_hdr_valid <= 1'b1;
                            r_state     <= HDR;
                        end else begin
                            r_req_valid <= 1'b1;
                            r_state     <= LOOKUP;
                        end
`else
                        r_req_valid <= 1'b1;
                        r_state     <= LOOKUP;
`endif
                    end
                end
                LOOKUP: begin
                    if (bus.arp_request_ready) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_state      <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.arp_response_valid) begin
                        r_resp_ready <= 1'b0;
                        if (bus.arp_response_error) begin
                            r_drop  <= 1'b1;
                            r_state <= DROP;
`ifdef IP_ARP_RESOLVE_CACHE_EN
                            if (r_cache_ip == r_dest_ip) r_cache_valid <= 1'b0;
`endif
                        end else begin
                            r_dest_mac  <= bus.arp_response_mac;
                            r_hdr_valid <= 1'b1;
                            r_state     <= HDR;
`ifdef IP_ARP_RESOLVE_CACHE_EN
                            r_cache_valid <= 1'b1;
                            r_cache_ip    <= r_dest_ip;
                            r_cache_mac   <= bus.arp_response_mac;
`endif
                        end
                    end
                end
                HDR: begin
                    if (bus.m_eth_hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                        r_state     <= PASS;
                    end
                end
                PASS, DROP: begin
                    if (w_in_fire && bus.s_ip_payload_axis_tlast) begin
                        r_hdr_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_arp_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip_arp_resolve
//  Brief    : Randomized self-checking bench; frames go in, the model predicts
//             which header/beats/requests/drop pulses must come out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ip_arp_resolve;

    localparam int DW = 64;
    localparam int KW = DW / 8;
`ifdef IP_ARP_RESOLVE_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] local_mac;
    logic        drop_frame;

    ip_arp_resolve_if #(.DATA_WIDTH(DW)) bus ();

    ip_arp_resolve #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .local_mac  (local_mac),
        .drop_frame (drop_frame),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Environment state shared by driver, sampler and the frame sequencer.
    bit          hdr_pend = 0;
    logic [31:0] hdr_ip   = '0;
    logic [47:0] hdr_lmac = '0;
    beat_t       in_q[$];
    bit          resp_pending = 0, resp_hold = 0, resp_err = 0;
    int          resp_delay = 0;
    logic [47:0] resp_mac = '0;
    int          req_block = 0, hdr_block = 0;
    bit          f_shdr = 0, f_sin = 0, f_req = 0, f_resp = 0;

    logic [31:0] obs_req[$];
    logic [47:0] obs_dmac[$], obs_smac[$];
    logic [15:0] obs_type[$];
    beat_t       obs_beats[$];
    int          drop_cnt = 0, stab_bad = 0;
    int          cyc = 0, acc_cyc = -1, hv_rise = -1, rq_rise = -1;

    // Reference cache (only consulted when the cache build is selected).
    bit          m_cv = 0;
    logic [31:0] m_cip = '0;
    logic [47:0] m_cmac = '0;

    // Sampler: observe handshakes half a cycle away from the active edge.
    initial begin
        beat_t       b;
        bit          p_rqv = 0, p_rqr = 0, p_hv = 0, p_hr = 0;
        logic [31:0] p_rqip = '0;
        logic [47:0] p_dmac = '0, p_smac = '0;
        forever begin
            @(negedge clk);
            cyc++;
            f_shdr = bus.s_ip_hdr_valid && bus.s_ip_hdr_ready;
            f_sin  = bus.s_ip_payload_axis_tvalid && bus.s_ip_payload_axis_tready;
            f_req  = bus.arp_request_valid && bus.arp_request_ready;
            f_resp = bus.arp_response_valid && bus.arp_response_ready;
            if (f_shdr) acc_cyc = cyc;
            if (bus.arp_request_valid && !p_rqv) rq_rise = cyc;
            if (bus.m_eth_hdr_valid && !p_hv) hv_rise = cyc;
            if (f_req) obs_req.push_back(bus.arp_request_ip);
            if (bus.m_eth_hdr_valid && bus.m_eth_hdr_ready) begin
                obs_dmac.push_back(bus.m_eth_dest_mac);
                obs_smac.push_back(bus.m_eth_src_mac);
                obs_type.push_back(bus.m_eth_type);
            end
            if (bus.m_eth_payload_axis_tvalid && bus.m_eth_payload_axis_tready) begin
                b.data = bus.m_eth_payload_axis_tdata;
                b.keep = bus.m_eth_payload_axis_tkeep;
                b.last = bus.m_eth_payload_axis_tlast;
                b.user = bus.m_eth_payload_axis_tuser;
                obs_beats.push_back(b);
            end
            if (drop_frame) drop_cnt++;
            if (!rst && p_rqv && !p_rqr && (!bus.arp_request_valid || bus.arp_request_ip != p_rqip))
                stab_bad++;
            if (!rst && p_hv && !p_hr && (!bus.m_eth_hdr_valid || bus.m_eth_dest_mac != p_dmac ||
                                          bus.m_eth_src_mac != p_smac))
                stab_bad++;
            if (bus.m_eth_hdr_valid && bus.s_ip_payload_axis_tready) stab_bad++;
            p_rqv  = bus.arp_request_valid;
            p_rqr  = bus.arp_request_ready;
            p_rqip = bus.arp_request_ip;
            p_hv   = bus.m_eth_hdr_valid;
            p_hr   = bus.m_eth_hdr_ready;
            p_dmac = bus.m_eth_dest_mac;
            p_smac = bus.m_eth_src_mac;
        end
    end

    // Driver: all TB-side inputs change 1 time unit after the rising edge.
    initial begin
        beat_t cur;
        bus.s_ip_hdr_valid = 0;             bus.s_ip_dest_ip = '0;
        bus.s_ip_payload_axis_tdata = '0;   bus.s_ip_payload_axis_tkeep = '0;
        bus.s_ip_payload_axis_tvalid = 0;   bus.s_ip_payload_axis_tlast = 0;
        bus.s_ip_payload_axis_tuser = 0;    bus.m_eth_hdr_ready = 0;
        bus.m_eth_payload_axis_tready = 0;  bus.arp_request_ready = 0;
        bus.arp_response_valid = 0;         bus.arp_response_error = 0;
        bus.arp_response_mac = '0;          local_mac = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                hdr_pend = 0;
                in_q.delete();
                resp_pending = 0;
                bus.s_ip_hdr_valid = 0;
                bus.s_ip_payload_axis_tvalid = 0;
                bus.arp_response_valid = 0;
            end else begin
                if (f_shdr) hdr_pend = 0;
                bus.s_ip_hdr_valid = hdr_pend;
                bus.s_ip_dest_ip   = hdr_ip;
                local_mac = hdr_pend ? hdr_lmac : 48'({$urandom(), $urandom()});

                if (f_sin) void'(in_q.pop_front());
                if (in_q.size() > 0) begin
                    if (!(bus.s_ip_payload_axis_tvalid && !f_sin))
                        bus.s_ip_payload_axis_tvalid = ($urandom_range(0, 3) != 0);
                    cur = in_q[0];
                    bus.s_ip_payload_axis_tdata = cur.data;
                    bus.s_ip_payload_axis_tkeep = cur.keep;
                    bus.s_ip_payload_axis_tlast = cur.last;
                    bus.s_ip_payload_axis_tuser = cur.user;
                end else begin
                    bus.s_ip_payload_axis_tvalid = 0;
                end

                if (bus.arp_request_valid && req_block > 0) begin
                    bus.arp_request_ready = 0;
                    req_block--;
                end else begin
                    bus.arp_request_ready = ($urandom_range(0, 1) == 1);
                end
                if (bus.m_eth_hdr_valid && hdr_block > 0) begin
                    bus.m_eth_hdr_ready = 0;
                    hdr_block--;
                end else begin
                    bus.m_eth_hdr_ready = ($urandom_range(0, 1) == 1);
                end
                bus.m_eth_payload_axis_tready = ($urandom_range(0, 2) != 0);

                if (f_req) begin
                    resp_pending = 1;
                    resp_delay   = int'($urandom_range(0, 4));
                end
                if (f_resp) begin
                    bus.arp_response_valid = 0;
                    resp_pending = 0;
                end else if (resp_pending && !resp_hold && !bus.arp_response_valid) begin
                    if (resp_delay == 0) begin
                        bus.arp_response_valid = 1;
                        bus.arp_response_mac   = resp_mac;
                        bus.arp_response_error = resp_err;
                    end else begin
                        resp_delay--;
                    end
                end
            end
        end
    end

    task automatic clear_obs();
        obs_req.delete();  obs_dmac.delete(); obs_smac.delete();
        obs_type.delete(); obs_beats.delete();
        drop_cnt = 0; stab_bad = 0; acc_cyc = -1; hv_rise = -1; rq_rise = -1;
    endtask

    // One frame: the model says a resolved frame emerges unchanged behind one
    // header; a failed lookup yields one drop pulse and nothing downstream.
    task automatic run_frame(input logic [31:0] ip, input logic [47:0] lmac, input int n,
                             input bit err, input logic [47:0] rmac);
        beat_t       exp_q[$];
        beat_t       b;
        bit          hit, eerr;
        logic [47:0] emac;
        int          w;
        hit  = CACHE_ON && m_cv && (m_cip == ip);
        eerr = hit ? 1'b0 : err;
        emac = hit ? m_cmac : rmac;
        if (!hit) begin
            if (!err) begin
                m_cv = 1; m_cip = ip; m_cmac = rmac;
            end else if (m_cip == ip) begin
                m_cv = 0;
            end
        end
        @(negedge clk);
        #1;
        clear_obs();
        resp_mac = rmac;
        resp_err = err;
        for (int i = 0; i < n; i++) begin
            b.data = {$urandom(), $urandom()};
            b.keep = (i == n - 1) ? KW'($urandom_range(1, 255)) : '1;
            b.last = (i == n - 1);
            b.user = (i == n - 1) && ($urandom_range(0, 3) == 0);
            in_q.push_back(b);
            if (!eerr) exp_q.push_back(b);
        end
        hdr_ip   = ip;
        hdr_lmac = lmac;
        hdr_pend = 1;
        for (w = 0; w < 3000; w++) begin
            @(negedge clk);
            if (!hdr_pend && in_q.size() == 0 && bus.s_ip_hdr_ready) break;
        end
        check_val("frame_timeout", 64'(w >= 3000), 64'd0);
        repeat (3) @(negedge clk);

        check_val("req_count", 64'(obs_req.size()), 64'(hit ? 0 : 1));
        if (obs_req.size() > 0) check_val("req_ip", 64'(obs_req[0]), 64'(ip));
        if (hit) check_val("hit_hdr_latency", 64'(hv_rise - acc_cyc), 64'd1);
        else     check_val("req_latency", 64'(rq_rise - acc_cyc), 64'd1);
        check_val("hdr_count", 64'(obs_dmac.size()), 64'(eerr ? 0 : 1));
        if (obs_dmac.size() > 0) begin
            check_val("dest_mac", 64'(obs_dmac[0]), 64'(emac));
            check_val("src_mac", 64'(obs_smac[0]), 64'(lmac));
            check_val("eth_type", 64'(obs_type[0]), 64'h0800);
        end
        check_val("beat_count", 64'(obs_beats.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_beats.size() && i < exp_q.size(); i++) begin
            check_val("beat_data", obs_beats[i].data, exp_q[i].data);
            check_val("beat_ctl", 64'({obs_beats[i].keep, obs_beats[i].last, obs_beats[i].user}),
                      64'({exp_q[i].keep, exp_q[i].last, exp_q[i].user}));
        end
        check_val("drop_pulses", 64'(drop_cnt), 64'(eerr));
        check_val("stability", 64'(stab_bad), 64'd0);
    endtask

    // Reset while a response is outstanding, then confirm everything cleared.
    task automatic reset_test();
        int w;
        resp_hold = 1;
        @(negedge clk);
        #1;
        clear_obs();
        hdr_ip   = 32'h0A0A0A0A;
        hdr_lmac = 48'h0200DEADBEEF;
        hdr_pend = 1;
        for (w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.arp_response_ready) break;
        end
        check_val("rst_reach_wait", 64'(w >= 200), 64'd0);
        #1 rst = 1;
        @(negedge clk);
        check_val("rst_hdr_ready", 64'(bus.s_ip_hdr_ready), 64'd0);
        check_val("rst_req_valid", 64'(bus.arp_request_valid), 64'd0);
        check_val("rst_resp_ready", 64'(bus.arp_response_ready), 64'd0);
        check_val("rst_hdr_valid", 64'(bus.m_eth_hdr_valid), 64'd0);
        check_val("rst_drop", 64'(drop_frame), 64'd0);
        check_val("rst_in_ready", 64'(bus.s_ip_payload_axis_tready), 64'd0);
        check_val("rst_out_valid", 64'(bus.m_eth_payload_axis_tvalid), 64'd0);
        check_val("rst_req_ip", 64'(bus.arp_request_ip), 64'd0);
        check_val("rst_dest_mac", 64'(bus.m_eth_dest_mac), 64'd0);
        #1 rst = 0;
        resp_hold = 0;
        resp_pending = 0;
        m_cv = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ip;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_hdr_ready", 64'(bus.s_ip_hdr_ready), 64'd0);
        check_val("reset_req_valid", 64'(bus.arp_request_valid), 64'd0);
        check_val("reset_hdr_valid", 64'(bus.m_eth_hdr_valid), 64'd0);
        check_val("reset_drop", 64'(drop_frame), 64'd0);
        check_val("reset_in_ready", 64'(bus.s_ip_payload_axis_tready), 64'd0);
        #1 rst = 0;
        repeat (2) @(negedge clk);
        check_val("idle_hdr_ready", 64'(bus.s_ip_hdr_ready), 64'd1);

        run_frame(32'hC0A80165, 48'h020000000001, 4, 1'b0, 48'h5A5152535455);
        run_frame(32'h0A000009, 48'h020000000002, 3, 1'b1, 48'h112233445566);
        req_block = 5;
        hdr_block = 3;
        run_frame(32'hAC100001, 48'h020000000003, 5, 1'b0, 48'h0A0B0C0D0E0F);
        run_frame(32'h0A000010, 48'h020000000004, 1, 1'b1, 48'h0);
        run_frame(32'h0A000011, 48'h020000000005, 1, 1'b0, 48'h665544332211);
        run_frame(32'hC0A80165, 48'h020000000006, 4, 1'b0, 48'h5A5152535455);
        run_frame(32'hC0A80165, 48'h020000000006, 2, 1'b0, 48'h5A5152535455);

        reset_test();
        run_frame(32'hC0A80165, 48'h020000000007, 4, 1'b0, 48'h5A5152535455);

        for (int k = 0; k < 16; k++) begin
            ip = ($urandom_range(0, 2) == 0) ? 32'hC0A80165 : $urandom();
            run_frame(ip, 48'({$urandom(), $urandom()}), int'($urandom_range(1, 6)),
                      ($urandom_range(0, 3) == 0), 48'({$urandom(), $urandom()}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
